pe_sequencer: RTL

PE_SEQUENCER -- requirements
Module: pe_sequencer

---
 rtl/pe_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pe_sequencer.sv
// pe_sequencer: job sequencer for a dot-product PE. It loads vector A and
// then vector B from operand memory (one element every 4 cycles, covering the
// 2-cycle read latency), steps the MAC L times, presents the result until it
// is acknowledged and pulses DONE. Every output is a flop loaded from the
// next-state decode, so no input reaches an output combinationally.
module pe_sequencer #(
  parameter int N  = 16,
  parameter int AW = $clog2(N) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [1:0]    DIMEN,
  output logic          MEM_RD,
  output logic [AW-1:0] MEM_ADDR,
  output logic [2:0]    latency_counter,
  output logic          RST_ADD,
  output logic          RST_ACC,
  output logic          RST_PC,
  output logic          WRITE_MAT,
  output logic          MAT_MUX,
  output logic          MAC_CTRL,
  output logic          OUT_READY,
  input  logic          OUT_ACK,
  input  logic          MAC_DONE,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR
);

  typedef enum logic [2:0] {
    IDLE, CLR, LOAD_A, REWIND, LOAD_B, MAC, OUT, FIN
  } state_t;

  // Control state
  state_t     state_q, state_d;
  logic [1:0] lreg_q, lreg_d;     // latched DIMEN of the running job
  logic [3:0] elem_q, elem_d;     // element index in loads, step count in MAC
  logic [1:0] phase_q, phase_d;   // read-latency phase within one element
  logic       out_first_q, out_first_d;
  logic       err_q, err_d;

  // Registered outputs
  logic          mem_rd_q, mem_rd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]    lat_q, lat_d;
  logic          rst_add_q, rst_add_d;
  logic          rst_acc_q, rst_acc_d;
  logic          rst_pc_q, rst_pc_d;
  logic          write_mat_q, write_mat_d;
  logic          mat_mux_q, mat_mux_d;
  logic          mac_ctrl_q, mac_ctrl_d;
  logic          out_ready_q, out_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [3:0] last_elem;
  logic       load_d;

  // L-1 for the latched length: L = 2 << DIMEN
  assign last_elem = 4'((5'd2 << lreg_q) - 5'd1);

  // Next-state and counter update; counters only advance below their
  // terminal value, so a load or MAC phase can never wrap into an extra element
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    lreg_d  = lreg_q;
    elem_d  = elem_q;
    phase_d = phase_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          lreg_d  = DIMEN;
          err_d   = 1'b0;
          state_d = CLR;
        end
      end
      CLR: begin
        elem_d  = '0;
        phase_d = '0;
        state_d = LOAD_A;
      end
      LOAD_A, LOAD_B: begin
        if (phase_q != 2'd3) begin
          phase_d = phase_q + 2'd1;
        end else if (elem_q != last_elem) begin
          elem_d  = elem_q + 4'd1;
          phase_d = '0;
        end else begin
          elem_d  = '0;
          phase_d = '0;
          state_d = (state_q == LOAD_A) ? REWIND : MAC;
        end
      end
      REWIND: state_d = LOAD_B;
      MAC: begin
        if (elem_q != last_elem) begin
          elem_d = elem_q + 4'd1;
        end else begin
          elem_d  = '0;
          state_d = OUT;
        end
      end
      OUT: begin
        // The PE pointer must have reached the end by the first OUT cycle
        if (out_first_q && (lreg_q < 2'd3) && !MAC_DONE) err_d = 1'b1;
        if (OUT_ACK) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state, so each output flop shows the state it belongs to
  always_comb begin
    load_d      = (state_d == LOAD_A) || (state_d == LOAD_B);
    out_first_d = (state_d == OUT) && (state_q != OUT);
    mem_rd_d    = load_d && (phase_d == 2'd0);
    mem_addr_d  = '0;
    if (state_d == LOAD_A) mem_addr_d = AW'(elem_d);
    if (state_d == LOAD_B) mem_addr_d = AW'(N) + AW'(elem_d);
    lat_d       = load_d ? {1'b0, phase_d} : 3'd0;
    rst_add_d   = (state_d == CLR) || (state_d == REWIND);
    rst_acc_d   = (state_d == CLR);
    rst_pc_d    = (state_d == CLR);
    write_mat_d = load_d;
    mat_mux_d   = (state_d == LOAD_A);
    mac_ctrl_d  = (state_d == MAC);
    out_ready_d = (state_d == OUT);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FIN);
  end

  // FSM and output registers with synchronous reset; reset also clears the PE
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
    if (RST) begin
      state_q     <= IDLE;
      lreg_q      <= '0;
      elem_q      <= '0;
      phase_q     <= '0;
      out_first_q <= 1'b0;
      err_q       <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      lat_q       <= '0;
      rst_add_q   <= 1'b1;
      rst_acc_q   <= 1'b1;
      rst_pc_q    <= 1'b1;
      write_mat_q <= 1'b0;
      mat_mux_q   <= 1'b0;
      mac_ctrl_q  <= 1'b0;
      out_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lreg_q      <= lreg_d;
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      out_first_q <= out_first_d;
      err_q       <= err_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      lat_q       <= lat_d;
      rst_add_q   <= rst_add_d;
      rst_acc_q   <= rst_acc_d;
      rst_pc_q    <= rst_pc_d;
      write_mat_q <= write_mat_d;
      mat_mux_q   <= mat_mux_d;
      mac_ctrl_q  <= mac_ctrl_d;
      out_ready_q <= out_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign MEM_RD          = mem_rd_q;
  assign MEM_ADDR        = mem_addr_q;
  assign latency_counter = lat_q;
  assign RST_ADD         = rst_add_q;
  assign RST_ACC         = rst_acc_q;
  assign RST_PC          = rst_pc_q;
  assign WRITE_MAT       = write_mat_q;
  assign MAT_MUX         = mat_mux_q;
  assign MAC_CTRL        = mac_ctrl_q;
  assign OUT_READY       = out_ready_q;
  assign BUSY            = busy_q;
  assign DONE            = done_q;
  assign ERR             = err_q;

endmodule
